// File: rtl/resource_arbiter_4_if.sv
// Request/grant bundle between the requesting agents, the shared resource and resource_arbiter_4.
// The arbiter owns the slave side; agents and the resource drive the master side.
interface resource_arbiter_4_if;
  // req[i] is level-sensitive and stays high until requester i has been served.
  // gnt is one-hot and registered; the owner keeps the resource while its req stays high.
  // done is a single-cycle completion strobe and is only observed during a grant.
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/resource_arbiter_4.sv
// Four-requester arbiter with grant hold, one-cycle release turnaround and hold timeout.
// Optional feature macro: ROUND_ROBIN_EN (rotating priority; otherwise fixed 3 > 2 > 1 > 0).
module resource_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  resource_arbiter_4_if.slave  bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       any_req;
  logic [1:0] winner;
  logic       owner_req;
  logic       hold_hit;

  assign any_req   = |bus.req;
  assign owner_req = bus.req[owner_q];
  // Compare against the value the counter is about to take, so the grant is
  // visible for MAX_HOLD-1 cycles before the limit revokes it.
  assign hold_hit  = (cnt_q == CNT_W'(MAX_HOLD - 2));

`ifdef ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [1:0] cand;
  logic       found;

  // Search last-1, last-2, last-3, then last itself: previous owner ranks lowest.
  always_comb begin
    winner = last_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q - 2'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req[i]) winner = 2'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
`ifdef ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef ROUND_ROBIN_EN
          last_d  = winner;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          owner_d = 2'd0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (bus.done || !owner_req || hold_hit) begin
          state_d   = RELEASE;
          gnt_d     = 4'b0000;
          owner_d   = 2'd0;
          busy_d    = 1'b0;
          // done and withdrawal take precedence: flag only a limit-only revoke.
          timeout_d = hold_hit && !bus.done && owner_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        owner_d = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 2'd0;
    else        last_q <= last_d;
  end
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_resource_arbiter_4.sv
// Directed bench for resource_arbiter_4 built with MAX_HOLD = 4.
// Expected grant sequences follow ROUND_ROBIN_EN when that macro is defined.
module tb_resource_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_tests;
  int         n_fail;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;
  logic [1:0] exp_id;

  resource_arbiter_4_if bus ();

  resource_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    check({tag, ".gnt"},     8'(bus.gnt),     8'(g));
    check({tag, ".gnt_id"},  8'(bus.gnt_id),  8'(id));
    check({tag, ".busy"},    8'(bus.busy),    8'(b));
    check({tag, ".timeout"}, 8'(bus.timeout), 8'(t));
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    repeat (2) tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("reset.state", 8'(state_dbg), 8'd0);
    rst_n = 1'b1;

    // done while idle is ignored
    bus.done = 1'b1;
    tick();
    chk_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.done = 1'b0;

    // single requester 0, done in the third grant cycle (coincides with the limit)
    bus.req = 4'b0001;
    tick();
    chk_out("t1.g1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk_out("t1.g2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk_out("t1.g3", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk_out("t1.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t1.state_rel", 8'(state_dbg), 8'd2);
    bus.done = 1'b0;
    tick();
    chk_out("t1.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_out("t1.withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check("t1.idle", 8'(state_dbg), 8'd0);

    // req = 1011 held, done every grant
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
`else
    repeat (4) exp_q.push_back(4'b1000);
`endif
    bus.req = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      tick();
      exp_g  = exp_q.pop_front();
      exp_id = idx_of(exp_g);
      chk_out($sformatf("t2.grant%0d", n), exp_g, exp_id, 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      chk_out($sformatf("t2.gap%0d", n), 4'b0000, 2'd0, 1'b0, 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 4'b0000;
    tick();
    check("t2.idle", 8'(state_dbg), 8'd0);

    // priority between 2 and 1 (also first choice after last = 3 in rotating mode)
    bus.req = 4'b0110;
    tick();
    chk_out("t3.prio", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    tick();

    // hold timeout: req = 0100 held, done never
    bus.req = 4'b0100;
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk_out($sformatf("t4.hold%0d", n), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    chk_out("t4.timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("t4.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_out("t4.rel2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    // withdrawal with a higher request arriving mid-grant (no preemption)
    bus.req = 4'b0010;
    tick();
    chk_out("t5.g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b1010;
    tick();
    chk_out("t5.nopreempt", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b1000;
    tick();
    chk_out("t5.withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("t5.next", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    tick();

    // asynchronous reset in the middle of a grant
    bus.req = 4'b0010;
    tick();
    chk_out("t6.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6.async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("t6.state", 8'(state_dbg), 8'd0);
    tick();
    chk_out("t6.rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("t6.after_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk_out("t6.end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
